// File: rtl/dshot_rx_autorate.sv
`default_nettype none
// ============================================================================
// Module      : dshot_rx_autorate
// Description : DShot frame decoder. It measures the bit rate of each frame
//               from the first bit, so DShot150, DShot300 and DShot600 work
//               without a rebuild. The decoder checks the 4-bit CRC, sorts the
//               throttle field into special commands (1..47) and speeds
//               (48..2047), and flags timing violations.
//               Optional build macro: DSHOT_BIDIR_EN selects inverted
//               bidirectional DShot with an inverted CRC. The line then idles
//               high.
// Revision    : 1.0 - initial release
// ============================================================================
module dshot_rx_autorate #(
    parameter int MIN_BIT_CYCLES = 16,
    parameter int MAX_BIT_CYCLES = 160,
    parameter int CNT_W          = 8,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inPin,
    output logic [10:0]      setSpeed,
    output logic             telemetryBit,
    output logic [5:0]       specialCommand,
    output logic             isSpecialCommand,
    output logic             isValidSpeed,
    output logic             CRCValid,
    output logic             processing,
    output logic             frameValid,
    output logic             frameError,
    output logic [CNT_W-1:0] bitPeriod
);

`ifdef DSHOT_BIDIR_EN
    localparam logic       c_INV     = 1'b1;
    localparam logic [3:0] c_CRC_XOR = 4'hF;
`else
    localparam logic       c_INV     = 1'b0;
    localparam logic [3:0] c_CRC_XOR = 4'h0;
`endif

    localparam logic [CNT_W:0] c_MIN = (CNT_W+1)'(MIN_BIT_CYCLES);
    localparam logic [CNT_W:0] c_MAX = (CNT_W+1)'(MAX_BIT_CYCLES);

    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_FIRST_HI = 3'd1;
    localparam logic [2:0] c_S_FIRST_LO = 3'd2;
    localparam logic [2:0] c_S_BIT_HI   = 3'd3;
    localparam logic [2:0] c_S_BIT_LO   = 3'd4;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_line_d;
    logic [2:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_hi0;
    logic [CNT_W-1:0]       r_period;
    logic [15:0]            r_shift;
    logic [4:0]             r_nbits;
    logic                   r_cmp;

    logic                   w_line;
    logic                   w_rise;
    logic                   w_fall;
    logic [CNT_W:0]         w_cnt_x;
    logic [CNT_W:0]         w_per_x;
    logic [2:0]             w_state_nxt;
    logic                   w_err;
    logic                   w_shift;
    logic                   w_bit;
    logic                   w_done;
    logic                   w_hi0_ld;
    logic                   w_per_ld;
    logic                   w_start;
    logic [3:0]             w_crc;
    logic                   w_crc_ok;
    logic [10:0]            w_throttle;
    logic                   w_is_spec;

    // Line polarity is normalised so that 1 always means the active pulse.
    assign w_line  = r_sync[SYNC_STAGES-1] ^ c_INV;
    assign w_rise  = w_line & ~r_line_d;
    assign w_fall  = ~w_line & r_line_d;
    assign w_cnt_x = {1'b0, r_cnt};
    assign w_per_x = {1'b0, r_period};

    // The synchroniser resets to the idle line level so that no false edge appears after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync   <= {SYNC_STAGES{c_INV}};
            r_line_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], inPin};
            r_line_d <= w_line;
        end
    end

    // This counter holds the cycles since the last accepted rise. It saturates, so long idle periods cannot wrap it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_rise) begin
            r_cnt <= CNT_W'(1);
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic, bit decisions and timing-violation detection.
    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_shift     = 1'b0;
        w_bit       = 1'b0;
        w_done      = 1'b0;
        w_hi0_ld    = 1'b0;
        w_per_ld    = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (w_rise) begin
                    w_start     = 1'b1;
                    w_state_nxt = c_S_FIRST_HI;
                end
            end
            c_S_FIRST_HI: begin
                if (w_fall) begin
                    w_hi0_ld    = 1'b1;
                    w_state_nxt = c_S_FIRST_LO;
                end else if (w_cnt_x > c_MAX) begin
                    w_err = 1'b1;
                end
            end
            c_S_FIRST_LO: begin
                // The rise-to-rise time of the first bit sets the reference for the whole frame.
                if (w_rise) begin
                    if ((w_cnt_x < c_MIN) || (w_cnt_x > c_MAX)) begin
                        w_err = 1'b1;
                    end else begin
                        w_per_ld    = 1'b1;
                        w_shift     = 1'b1;
                        w_bit       = ({r_hi0, 1'b0} > w_cnt_x);
                        w_state_nxt = c_S_BIT_HI;
                    end
                end else if (w_cnt_x > c_MAX) begin
                    w_err = 1'b1;
                end
            end
            c_S_BIT_HI: begin
                if (w_fall) begin
                    w_shift = 1'b1;
                    w_bit   = ({r_cnt, 1'b0} > w_per_x);
                    if (r_nbits == 5'd15) begin
                        w_done      = 1'b1;
                        w_state_nxt = c_S_IDLE;
                    end else begin
                        w_state_nxt = c_S_BIT_LO;
                    end
                end else if (w_cnt_x > c_MAX) begin
                    w_err = 1'b1;
                end
            end
            c_S_BIT_LO: begin
                if (w_rise) begin
                    if (w_cnt_x < {2'b00, r_period[CNT_W-1:1]}) begin
                        w_err = 1'b1;
                    end else begin
                        w_state_nxt = c_S_BIT_HI;
                    end
                end else if (w_cnt_x > (w_per_x + (w_per_x >> 1))) begin
                    w_err = 1'b1;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
        if (w_err) begin
            w_state_nxt = c_S_IDLE;
        end
    end

    // The frame is complete, so it is checked here. The CRC covers the 12-bit value, and the throttle is the top 11 bits.
    assign w_crc      = r_shift[15:12] ^ r_shift[11:8] ^ r_shift[7:4] ^ c_CRC_XOR;
    assign w_crc_ok   = (w_crc == r_shift[3:0]);
    assign w_throttle = r_shift[15:5];
    assign w_is_spec  = (w_throttle != 11'd0) && (w_throttle < 11'd48);

    // This block captures frame bits and timing references.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift  <= '0;
            r_nbits  <= '0;
            r_hi0    <= '0;
            r_period <= '0;
            r_cmp    <= 1'b0;
        end else begin
            r_cmp <= w_done;
            if (w_hi0_ld) begin
                r_hi0 <= r_cnt;
            end
            if (w_per_ld) begin
                r_period <= r_cnt;
            end
            if (w_shift) begin
                r_shift <= {r_shift[14:0], w_bit};
                r_nbits <= w_per_ld ? 5'd1 : (r_nbits + 5'd1);
            end
        end
    end

    // This block registers the outputs. The completion cycle follows the last falling edge. A rise in that same cycle starts the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            setSpeed         <= '0;
            telemetryBit     <= 1'b0;
            specialCommand   <= '0;
            isSpecialCommand <= 1'b0;
            isValidSpeed     <= 1'b0;
            CRCValid         <= 1'b0;
            processing       <= 1'b0;
            frameValid       <= 1'b0;
            frameError       <= 1'b0;
            bitPeriod        <= '0;
        end else begin
            frameError <= w_err;
            frameValid <= 1'b0;
            if (w_start) begin
                processing <= 1'b1;
            end else if (w_err || r_cmp) begin
                processing <= 1'b0;
            end
            if (r_cmp) begin
                CRCValid   <= w_crc_ok;
                bitPeriod  <= r_period;
                frameValid <= w_crc_ok;
                if (w_crc_ok) begin
                    setSpeed         <= w_throttle;
                    telemetryBit     <= r_shift[4];
                    specialCommand   <= w_is_spec ? w_throttle[5:0] : 6'd0;
                    isSpecialCommand <= w_is_spec;
                    isValidSpeed     <= (w_throttle >= 11'd48);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dshot_rx_autorate.sv
`default_nettype none
// ============================================================================
// Module      : tb_dshot_rx_autorate
// Description : Directed, table-driven bench for dshot_rx_autorate. Frames are
//               written with their plain CRC. When the bench is built with
//               DSHOT_BIDIR_EN, it inverts the line and the CRC nibble, so the
//               expected decode stays the same.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dshot_rx_autorate;

`ifdef DSHOT_BIDIR_EN
    localparam logic        c_INV      = 1'b1;
    localparam logic [15:0] c_CRC_FLIP = 16'h000F;
`else
    localparam logic        c_INV      = 1'b0;
    localparam logic [15:0] c_CRC_FLIP = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inPin = c_INV;
    logic [10:0] setSpeed;
    logic        telemetryBit;
    logic [5:0]  specialCommand;
    logic        isSpecialCommand;
    logic        isValidSpeed;
    logic        CRCValid;
    logic        processing;
    logic        frameValid;
    logic        frameError;
    logic [7:0]  bitPeriod;

    dshot_rx_autorate dut (
        .clk              (clk),
        .rst              (rst),
        .inPin            (inPin),
        .setSpeed         (setSpeed),
        .telemetryBit     (telemetryBit),
        .specialCommand   (specialCommand),
        .isSpecialCommand (isSpecialCommand),
        .isValidSpeed     (isValidSpeed),
        .CRCValid         (CRCValid),
        .processing       (processing),
        .frameValid       (frameValid),
        .frameError       (frameError),
        .bitPeriod        (bitPeriod)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] frame;
        int          period;
        int          speed;
        int          tlm;
        int          cmd;
        int          spec;
        int          valid;
        int          crc;
        int          fv;
    } vec_t;

    vec_t tbl[8];
    int   checks    = 0;
    int   failures  = 0;
    int   fv_cnt    = 0;
    int   fe_cnt    = 0;
    int   both_cnt  = 0;

    // Strobe counters.
    always @(negedge clk) begin
        if (frameValid) fv_cnt++;
        if (frameError) fe_cnt++;
        if (frameValid && frameError) both_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic drive(input logic level, input int n);
        inPin = level ^ c_INV;
        repeat (n) @(negedge clk);
    endtask

    // A "1" bit is high for 75% of the period and a "0" bit for 37.5%, both rounded.
    task automatic send_bits(input logic [15:0] frame, input int p, input int nbits);
        int h;
        for (int i = 15; i > 15 - nbits; i--) begin
            h = frame[i] ? (3 * p + 2) / 4 : (3 * p + 4) / 8;
            drive(1'b1, h);
            drive(1'b0, p - h);
        end
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        int fv0;
        int fe0;
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        send_bits(v.frame ^ c_CRC_FLIP, v.period, 16);
        drive(1'b0, 20);
        check($sformatf("v%0d setSpeed", idx), int'(setSpeed), v.speed);
        check($sformatf("v%0d telemetryBit", idx), int'(telemetryBit), v.tlm);
        check($sformatf("v%0d specialCommand", idx), int'(specialCommand), v.cmd);
        check($sformatf("v%0d isSpecialCommand", idx), int'(isSpecialCommand), v.spec);
        check($sformatf("v%0d isValidSpeed", idx), int'(isValidSpeed), v.valid);
        check($sformatf("v%0d CRCValid", idx), int'(CRCValid), v.crc);
        check($sformatf("v%0d bitPeriod", idx), int'(bitPeriod), v.period);
        check($sformatf("v%0d frameValid count", idx), fv_cnt - fv0, v.fv);
        check($sformatf("v%0d frameError count", idx), fe_cnt - fe0, 0);
        check($sformatf("v%0d processing", idx), int'(processing), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " setSpeed"}, int'(setSpeed), 0);
        check({tag, " telemetryBit"}, int'(telemetryBit), 0);
        check({tag, " specialCommand"}, int'(specialCommand), 0);
        check({tag, " isSpecialCommand"}, int'(isSpecialCommand), 0);
        check({tag, " isValidSpeed"}, int'(isValidSpeed), 0);
        check({tag, " CRCValid"}, int'(CRCValid), 0);
        check({tag, " processing"}, int'(processing), 0);
        check({tag, " frameValid"}, int'(frameValid), 0);
        check({tag, " frameError"}, int'(frameError), 0);
        check({tag, " bitPeriod"}, int'(bitPeriod), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   fv0;
        int   fe0;
        int   n;
        vec_t rec;

        //                frame     per  spd  tlm cmd sp vs crc fv
        tbl[0] = '{16'hDEA9, 107, 1781, 0,  0, 0, 1, 1, 1};
        tbl[1] = '{16'hDEA9,  27, 1781, 0,  0, 0, 1, 1, 1};
        tbl[2] = '{16'hDEA8,  53, 1781, 0,  0, 0, 1, 0, 0};
        tbl[3] = '{16'h0033,  53,    1, 1,  1, 1, 0, 1, 1};
        tbl[4] = '{16'h0000,  27,    0, 0,  0, 0, 0, 1, 1};
        tbl[5] = '{16'h05EB, 107,   47, 0, 47, 1, 0, 1, 1};
        tbl[6] = '{16'h0606,  53,   48, 0,  0, 0, 1, 1, 1};
        tbl[7] = '{16'hFFFF,  27, 2047, 1,  0, 0, 1, 1, 1};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        drive(1'b0, 10);

        for (int i = 0; i < 8; i++) begin
            apply_vec(tbl[i], i);
        end

        // The line stops low after the rise of the 9th bit. A timeout is expected about 1.5*107 cycles after that rise, plus the input latency.
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        send_bits(16'hDEA9 ^ c_CRC_FLIP, 107, 8);
        check("stall processing mid-frame", int'(processing), 1);
        drive(1'b1, 80);
        inPin = c_INV;
        n = 0;
        while (!frameError && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_range("stall timeout cycles", 80 + n, 158, 170);
        check("stall processing", int'(processing), 0);
        repeat (2) @(negedge clk);
        check("stall frameError count", fe_cnt - fe0, 1);
        check("stall frameValid count", fv_cnt - fv0, 0);
        check("stall setSpeed held", int'(setSpeed), 2047);
        drive(1'b0, 20);
        rec = '{16'hDEA9, 53, 1781, 0, 0, 0, 1, 1, 1};
        apply_vec(rec, 8);

        // Reset is asserted during the high phase of bit 8. The outputs must clear at once, and no strobe may follow.
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        send_bits(16'h0033 ^ c_CRC_FLIP, 53, 8);
        inPin = 1'b1 ^ c_INV;
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        inPin = c_INV;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 300);
        check("midreset frameValid count", fv_cnt - fv0, 0);
        check("midreset frameError count", fe_cnt - fe0, 0);
        check("midreset setSpeed after", int'(setSpeed), 0);
        apply_vec(tbl[3], 9);

        check("strobes never coincide", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
